// File: rtl/mdu_sched_pkg.sv
// rtl/mdu_sched_pkg.sv - shared MDU operation encodings and helpers
package mdu_sched_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  // True for the ops that open a multi-cycle busy window
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // True for the two divide flavours (they use the longer window)
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide result generator
module mdu_arith
  import mdu_sched_pkg::*;
(
  input  logic [3:0]  md_type,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] safe_rt;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] uq_mag;
  logic [31:0] ur_mag;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // A zero divisor is replaced by 1 so the dividers never see /0; the
  // scheduler drops the result anyway via div_zero.
  assign safe_rt = (rt == 32'd0) ? 32'd1 : rt;

  // Signed divide done on magnitudes so 0x80000000 / -1 needs no special case
  assign rs_mag = rs[31] ? (32'd0 - rs) : rs;
  assign rt_mag = safe_rt[31] ? (32'd0 - safe_rt) : safe_rt;
  assign uq_mag = rs_mag / rt_mag;
  assign ur_mag = rs_mag % rt_mag;
  assign sq     = (rs[31] ^ safe_rt[31]) ? (32'd0 - uq_mag) : uq_mag;
  assign sr     = rs[31] ? (32'd0 - ur_mag) : ur_mag;

  assign uq = rs / safe_rt;
  assign ur = rs % safe_rt;

  // Select the {HI,LO} pair for the requested operation
  always_comb begin
    hi       = 32'd0;
    lo       = 32'd0;
    div_zero = 1'b0;
    case (md_type)
      MDU_MULT:  {hi, lo} = prod_s;
      MDU_MULTU: {hi, lo} = prod_u;
      MDU_DIV: begin
        hi       = sr;
        lo       = sq;
        div_zero = (rt == 32'd0);
      end
      MDU_DIVU: begin
        hi       = ur;
        lo       = uq;
        div_zero = (rt == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// rtl/mdu_sched.sv - multi-cycle multiply/divide scheduler owning HI/LO
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        req,
  input  logic [3:0]  md_type,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] md_out
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_zero;

  logic [31:0] arith_hi;
  logic [31:0] arith_lo;
  logic        arith_zero;
  logic        accept;
  logic        commit;
  logic        mt_ok;

  mdu_arith u_arith (
    .md_type  (md_type),
    .rs       (rs),
    .rt       (rt),
    .hi       (arith_hi),
    .lo       (arith_lo),
    .div_zero (arith_zero)
  );

  // A flushed instruction (req) never starts an op or writes HI/LO
  assign accept = (state_q == IDLE) && start && !req && is_arith_op(md_type);
  assign mt_ok  = (state_q == IDLE) && !req &&
                  ((md_type == MDU_MTHI) || (md_type == MDU_MTLO));
  assign commit = (state_q == RUN) && (cnt_q == 4'd1);
  assign busy   = (state_q == RUN);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: leave RUN on the last counted cycle, ignore start while RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Busy-window counter, pending result capture and HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_zero <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q     <= is_div_op(md_type) ? DIV_N : MUL_N;
        pend_hi   <= arith_hi;
        pend_lo   <= arith_lo;
        pend_zero <= arith_zero;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit && !pend_zero) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
      if (mt_ok && (md_type == MDU_MTHI)) hi_q <= rs;
      if (mt_ok && (md_type == MDU_MTLO)) lo_q <= rs;
    end
  end

  // Read port for mfhi/mflo, always from the architectural registers
  always_comb begin
    md_out = 32'd0;
    if (md_type == MDU_MFHI)      md_out = hi_q;
    else if (md_type == MDU_MFLO) md_out = lo_q;
  end

endmodule

// File: tb/tb_mdu_sched.sv
// tb/tb_mdu_sched.sv - self-checking bench for mdu_sched
module tb_mdu_sched;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        req;
  logic [3:0]  md_type;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] md_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          nb;

  always #5 clk = ~clk;

  mdu_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .req     (req),
    .md_type (md_type),
    .rs      (rs),
    .rt      (rt),
    .busy    (busy),
    .md_out  (md_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI,LO} from plain integer arithmetic
  function automatic logic [63:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint x;
    longint y;
    longint q;
    longint r;
    logic [63:0] p;
    x = $signed(a);
    y = $signed(b);
    p = 64'd0;
    case (op)
      OP_MULT:  begin q = x * y; p = q; end
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_DIV:   begin q = x / y; r = x % y; p = {r[31:0], q[31:0]}; end
      OP_DIVU:  p = {a % b, a / b};
      default:  p = 64'd0;
    endcase
    return p;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rq, output int n);
    logic arith;
    logic [63:0] res;
    arith = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    @(negedge clk);
    chk("idle_before_issue", {31'd0, busy}, 32'd0);
    md_type = op; rs = a; rt = b; req = rq; start = arith;
    @(negedge clk);
    start = 1'b0; req = 1'b0; md_type = OP_NONE; rs = 32'd0; rt = 32'd0;
    n = 0;
    if (!rq) begin
      if (arith) begin
        n = ((op == OP_DIV) || (op == OP_DIVU)) ? 10 : 5;
        if (!(((op == OP_DIV) || (op == OP_DIVU)) && b == 32'd0)) begin
          res  = ref_result(op, a, b);
          m_hi = res[63:32];
          m_lo = res[31:0];
        end
      end else if (op == OP_MTHI) begin
        m_hi = a;
      end else if (op == OP_MTLO) begin
        m_lo = a;
      end
    end
  endtask

  // Called at the negedge of the first cycle after issue
  task automatic wait_busy(input int n, input int req_at);
    for (int i = 0; i < n; i++) begin
      chk("busy_high", {31'd0, busy}, 32'd1);
      if (i == req_at) req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    chk("busy_low_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_hilo(input string tag);
    md_type = OP_MFHI; #1;
    chk({tag, "_hi"}, md_out, m_hi);
    md_type = OP_MFLO; #1;
    chk({tag, "_lo"}, md_out, m_lo);
    md_type = OP_NONE; #1;
    chk({tag, "_none"}, md_out, 32'd0);
  endtask

  initial begin
    logic [3:0]  ops [6];
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rq;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

    reset = 1'b1; start = 1'b0; req = 1'b0; md_type = OP_NONE; rs = 32'd0; rt = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    check_hilo("reset");

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, nb);
    wait_busy(nb, -1);
    chk("multu_hi_const", m_hi, 32'h0000_0001);
    check_hilo("multu");

    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, nb);
    wait_busy(nb, -1);
    check_hilo("mult_neg");

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, nb);
    wait_busy(nb, -1);
    chk("div_lo_const", m_lo, 32'hFFFF_FFFD);
    check_hilo("div_neg");

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb);
    wait_busy(nb, -1);
    check_hilo("div_ovf");

    issue(OP_MTHI, 32'h11, 32'd0, 1'b0, nb);
    wait_busy(nb, -1);
    issue(OP_MTLO, 32'h22, 32'd0, 1'b0, nb);
    wait_busy(nb, -1);
    check_hilo("mt");
    issue(OP_DIVU, 32'd7, 32'd0, 1'b0, nb);
    wait_busy(nb, -1);
    check_hilo("divu_zero");

    issue(OP_MULT, 32'd3, 32'd4, 1'b1, nb);
    wait_busy(nb, -1);
    check_hilo("flush_mult");
    issue(OP_MTLO, 32'h55, 32'd0, 1'b1, nb);
    wait_busy(nb, -1);
    check_hilo("flush_mtlo");

    issue(OP_MULT, 32'd3, 32'd4, 1'b0, nb);
    wait_busy(nb, 1);
    check_hilo("req_in_run");

    issue(OP_DIV, 32'd100, 32'd7, 1'b0, nb);
    for (int i = 0; i < 3; i++) begin
      chk("busy_before_rst", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("busy_after_rst", {31'd0, busy}, 32'd0);
    check_hilo("mid_rst");

    for (int k = 0; k < 24; k++) begin
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      if ($urandom_range(0, 4) == 0)      b = 32'd0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else                                b = $urandom_range(1, 20);
      rq = ($urandom_range(0, 5) == 0);
      issue(op, a, b, rq, nb);
      wait_busy(nb, -1);
      check_hilo("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
